// File: rtl/cpu_req_gen.sv
// cpu_req_gen: programmable load/store request engine feeding L1.
// Optional watchdog abort is built when REQ_GEN_TIMEOUT_EN is defined.
module cpu_req_gen #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 8,
  parameter int NUM_REQ = 16,
  parameter int STRIDE  = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              istart,
  input  logic [1:0]        imode,
  input  logic [ADDR_W-1:0] ibase_addr,
  input  logic [3:0]        iwr_every,
  output logic              ovalid,
  input  logic              iready,
  output logic [ADDR_W-1:0] oaddress,
  output logic              oRW,
  output logic [DATA_W-1:0] owrite_data,
  input  logic              iresp_valid,
  input  logic [DATA_W-1:0] iread_data,
  input  logic              iL1miss,
  input  logic              iL2miss,
  output logic              obusy,
  output logic              odone,
  output logic              oerror,
  output logic [CNT_W-1:0]  oreq_cnt,
  output logic [CNT_W-1:0]  ol1_miss_cnt,
  output logic [CNT_W-1:0]  ol2_miss_cnt,
  output logic [DATA_W-1:0] ochecksum
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [1:0]        mode;
  logic [3:0]        wr_every;
  logic [3:0]        wr_cnt;
  logic [3:0]        wr_cnt_nxt;
  logic [15:0]       lfsr;
  logic [15:0]       lfsr_step;
  logic [15:0]       seed;
  logic [ADDR_W-1:0] addr_nxt;
  logic              start;
  logic              resp;
  logic              last;
  logic              timeout;

`ifdef REQ_GEN_TIMEOUT_EN
  logic [7:0] wd_cnt;
`endif

  // Seed, LFSR step, next address and write-interval countdown.
  always_comb begin
    seed = (ibase_addr == '0) ? 16'h0001 : 16'(ibase_addr);
    lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    wr_cnt_nxt = (wr_cnt == 4'd0) ? wr_every - 4'd1 : wr_cnt - 4'd1;
    addr_nxt = oaddress;
    unique case (mode)
      2'b00: addr_nxt = oaddress + ADDR_W'(1);
      2'b01: addr_nxt = oaddress + ADDR_W'(STRIDE);
      2'b10: addr_nxt = lfsr_step[ADDR_W-1:0];
      2'b11: addr_nxt = oaddress;
    endcase
  end

  // Next-state logic and per-cycle events.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    resp      = 1'b0;
    last      = 1'b0;
    timeout   = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (istart) begin
          start     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (iready) state_nxt = WAIT;
      end
      WAIT: begin
        if (iresp_valid) begin
          resp      = 1'b1;
          last      = (oreq_cnt + CNT_W'(1)) == CNT_W'(NUM_REQ);
          state_nxt = last ? DONE : ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef REQ_GEN_TIMEOUT_EN
    if ((state == ISSUE || state == WAIT) &&
        state_nxt == state && wd_cnt == 8'hFF) begin
      state_nxt = DONE;
      timeout   = 1'b1;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Request fields, statistics and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovalid       <= 1'b0;
      oaddress     <= '0;
      oRW          <= 1'b1;
      owrite_data  <= '0;
      obusy        <= 1'b0;
      odone        <= 1'b0;
      oreq_cnt     <= '0;
      ol1_miss_cnt <= '0;
      ol2_miss_cnt <= '0;
      ochecksum    <= '0;
      mode         <= 2'b00;
      wr_every     <= 4'd0;
      wr_cnt       <= 4'd0;
      lfsr         <= 16'h0001;
    end else begin
      ovalid <= (state_nxt == ISSUE);
      obusy  <= (state_nxt == ISSUE) || (state_nxt == WAIT);
      odone  <= (state_nxt == DONE);
      if (start) begin
        oreq_cnt     <= '0;
        ol1_miss_cnt <= '0;
        ol2_miss_cnt <= '0;
        ochecksum    <= '0;
        oaddress     <= (imode == 2'b10) ? seed[ADDR_W-1:0]
                                         : ibase_addr;
        lfsr         <= seed;
        mode         <= imode;
        wr_every     <= iwr_every;
        wr_cnt       <= iwr_every - 4'd1;
        oRW          <= (iwr_every != 4'd1);
        owrite_data  <= '0;
      end
      if (resp) begin
        if (oreq_cnt != '1)
          oreq_cnt <= oreq_cnt + CNT_W'(1);
        if (iL1miss && ol1_miss_cnt != '1)
          ol1_miss_cnt <= ol1_miss_cnt + CNT_W'(1);
        if (iL2miss && ol2_miss_cnt != '1)
          ol2_miss_cnt <= ol2_miss_cnt + CNT_W'(1);
        if (oRW)
          ochecksum <= ochecksum ^ iread_data;
        if (!last) begin
          oaddress    <= addr_nxt;
          wr_cnt      <= wr_cnt_nxt;
          oRW         <= !(wr_every != 4'd0 && wr_cnt_nxt == 4'd0);
          owrite_data <= owrite_data + DATA_W'(1);
          if (mode == 2'b10) lfsr <= lfsr_step;
        end
      end
    end
  end

`ifdef REQ_GEN_TIMEOUT_EN
  // Watchdog: counts cycles spent in one active state.
  always_ff @(posedge clk) begin
    if (rst)
      wd_cnt <= '0;
    else if (state_nxt != state || !(state == ISSUE || state == WAIT))
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + 8'd1;
  end

  // Error flag: set on watchdog abort, cleared on start.
  always_ff @(posedge clk) begin
    if (rst)          oerror <= 1'b0;
    else if (start)   oerror <= 1'b0;
    else if (timeout) oerror <= 1'b1;
  end
`else
  assign oerror = 1'b0;
`endif

endmodule

// File: doc/cpu_req_gen.md
# cpu_req_gen

Parametrised CPU-side request generator for the two-level cache hierarchy. It replaces hand-sequenced address stimulus with an on-chip engine that issues a programmable number of load/store requests (sequential, strided, pseudo-random or hotspot addresses), one outstanding at a time, over a valid/ready handshake into L1. It also accumulates request, L1-miss and L2-miss counts plus a read-data checksum for hit-rate measurement.

## Interface
Parameters:
- ADDR_W, 11: address width; legal range 4..16.
- DATA_W, 8: data width.
- NUM_REQ, 16: requests issued per run; legal range 1..2^CNT_W-1.
- STRIDE, 4: address increment in stride mode.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- istart  in  1  start pulse; honoured only in IDLE or DONE.
- imode  in  2  address mode: 00 sequential, 01 stride, 10 LFSR random, 11 hotspot (same address every request); sampled at start.
- ibase_addr  in  ADDR_W  first address, and LFSR seed; sampled at start.
- iwr_every  in  4  write interval; 0 means all reads; sampled at start.
- ovalid  out  1  request valid.
- iready  in  1  L1 accepts the request.
- oaddress  out  ADDR_W  request address.
- oRW  out  1  1 = read, 0 = write.
- owrite_data  out  DATA_W  store data.
- iresp_valid  in  1  L1 response for the outstanding request.
- iread_data  in  DATA_W  load data, valid with iresp_valid.
- iL1miss  in  1  response missed L1; valid with iresp_valid.
- iL2miss  in  1  response missed L2; valid with iresp_valid.
- obusy  out  1  run in progress.
- odone  out  1  run finished; held until the next start or reset.
- oerror  out  1  run aborted by the watchdog.
- oreq_cnt  out  CNT_W  completed requests.
- ol1_miss_cnt  out  CNT_W  L1 misses.
- ol2_miss_cnt  out  CNT_W  L2 misses.
- ochecksum  out  DATA_W  XOR of all read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE/DONE -> ISSUE on istart:
  - Clear all counters, ochecksum, odone and oerror.
  - Load address = ibase_addr. In LFSR mode, seed = zero-extended ibase_addr, or 16'h0001 if that value is 0.
  - Latch imode and iwr_every.
- ISSUE: ovalid=1. When ovalid && iready, go to WAIT.
- WAIT: when iresp_valid:
  - Increment oreq_cnt. Increment ol1_miss_cnt if iL1miss, and ol2_miss_cnt if iL2miss; the two are independent.
  - On a read, XOR iread_data into ochecksum.
  - If oreq_cnt+1 == NUM_REQ go to DONE; otherwise advance the address and go to ISSUE.
- Address advance, all modulo 2^ADDR_W:
  - Sequential: +1.
  - Stride: +STRIDE.
  - LFSR: 16-bit Galois LFSR, taps 16'hB400, stepped once per request; address = lfsr[ADDR_W-1:0].
  - Hotspot: unchanged.
- Request k (0-based) is a write iff iwr_every != 0 and (k mod iwr_every) == iwr_every-1. Implement with a down-counter, not a divider.
- Write data: owrite_data = k[DATA_W-1:0].
- Statistics counters saturate at all-ones.
- istart in ISSUE/WAIT is ignored.
- iresp_valid outside WAIT is ignored.

## Timing
- All outputs are registered. Reset values: ovalid=0, oaddress=0, oRW=1, owrite_data=0, obusy=0, odone=0, oerror=0, all counters 0, ochecksum=0, FSM=IDLE.
- istart sampled at edge t: ovalid=1 and obusy=1 from t+1.
- oaddress, oRW and owrite_data are stable while ovalid && !iready. ovalid drops the cycle after acceptance.
- The earliest response is one cycle after acceptance. The next ovalid follows one cycle after iresp_valid (one-cycle bubble).
- Last response at edge t: odone=1 and obusy=0 from t+1. Counters hold their final values until the next start.
- rst mid-run: FSM returns to IDLE on that edge, and every output takes its reset value the next cycle. The outstanding request is abandoned.

## Configuration
- REQ_GEN_TIMEOUT_EN defined:
  - An 8-bit watchdog counter clears on every state change.
  - If the FSM stays 256 consecutive cycles in ISSUE or WAIT, it goes to DONE with oerror=1 and odone=1; counters keep their partial values.
- Not defined: no watchdog; oerror is tied 0; the block waits indefinitely.

## Test plan
- Sequential run: NUM_REQ=4, ibase=0x7FE, mode 00, iready=1, response 1 cycle after acceptance, no misses -> addresses 0x7FE, 0x7FF, 0x000, 0x001; oreq_cnt=4; odone after the 4th response.
- Backpressure: mode 01, STRIDE=4, ibase=0x010, iready low for 3 cycles on request 1 -> oaddress holds 0x014 while stalled; ovalid held; no duplicate acceptance.
- Write mix: iwr_every=3, NUM_REQ=6 -> requests 2 and 5 have oRW=0 with owrite_data 0x02 and 0x05; ochecksum covers only the 4 reads (iread_data=0xAA each -> 0x00).
- Miss statistics: mode 11, ibase=0x123, first response iL1miss=1 and iL2miss=1, the rest hits -> ol1_miss_cnt=1, ol2_miss_cnt=1; all addresses 0x123.
- LFSR plus reset: mode 10, ibase=0 -> seed 0x0001, first address 0x001, second 0x400 (LFSR 0xB400 truncated to 11 bits); assert rst during WAIT -> all outputs at reset values the next cycle; istart is honoured afterwards.
- Watchdog (REQ_GEN_TIMEOUT_EN): request accepted, iresp_valid never asserted -> oerror=1 and odone=1 after 256 cycles in WAIT; without the macro, obusy stays 1.
